// File: rtl/i2c_pkg.sv
// Shared definitions for the single-byte I2C write master:
// the controller state encoding and the default SCL divider.
package i2c_pkg;

  // clk cycles per SCL quarter period (100 MHz clk -> 100 kHz SCL)
  localparam int CLK_DIV_DEFAULT = 250;

  typedef enum logic [2:0] {
    IDLE,
    START,
    ADDR,
    ADDR_ACK,
    DATA,
    DATA_ACK,
    STOP,
    DONE
  } state_t;

endpackage

// File: rtl/i2c_clk_gen.sv
// Quarter-phase timing for the I2C master. While run is high, a divider
// counts CLK_DIV clk cycles per quarter and a 2-bit phase index walks
// Q0..Q3 once per bit time. hold freezes the divider (clock stretching).
module i2c_clk_gen
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       hold,
  output logic       tick,
  output logic [1:0] phase,
  output logic       bit_end
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       phase_q, phase_d;

  // Advance the quarter divider and phase; both sit at zero while idle.
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    tick    = 1'b0;
    if (!run) begin
      cnt_d   = '0;
      phase_d = 2'd0;
    end else if (!hold) begin
      if (cnt_q == CNT_MAX) begin
        tick    = 1'b1;
        cnt_d   = '0;
        phase_d = phase_q + 2'd1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Divider and phase registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q   <= '0;
      phase_q <= 2'd0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign phase   = phase_q;
  assign bit_end = tick && (phase_q == 2'd3);

endmodule

// File: rtl/i2c_master_single_byte.sv
// Single-byte I2C write master: START, 7-bit address + W, ACK, one data
// byte, ACK, STOP. A NACK on the address skips the data byte.
// Optional feature macro: I2C_CLK_STRETCH_EN -- when defined, the quarter
// timer holds while SCL is released but still read low (slave stretching).
module i2c_master_single_byte
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [6:0] addr,
  input  logic       wr_start,
  input  logic [7:0] wr_byte,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       scl_oe,
  output logic       sda_oe,
  input  logic       scl_i,
  input  logic       sda_i
);

  state_t     state_q, state_d;
  logic [6:0] addr_q, addr_d;
  logic [7:0] data_q, data_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       ack_err_q, ack_err_d;

  logic       run;
  logic       hold;
  logic       tick;
  logic [1:0] phase;
  logic       bit_end;
  logic       sample;
  logic [7:0] addr_byte;

  assign run       = (state_q != IDLE) && (state_q != DONE);
  assign sample    = tick && (phase == 2'd2);
  assign addr_byte = {addr_q, 1'b0};

`ifdef I2C_CLK_STRETCH_EN
  assign hold = run && !scl_oe && !scl_i && ((phase == 2'd1) || (phase == 2'd2));
`else
  logic unused_scl_i;
  assign unused_scl_i = scl_i;
  assign hold         = 1'b0;
`endif

  i2c_clk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_clk_gen (
    .clk    (clk),
    .rst    (rst),
    .run    (run),
    .hold   (hold),
    .tick   (tick),
    .phase  (phase),
    .bit_end(bit_end)
  );

  // Next-state logic: sequence the frame one bit time at a time and record NACKs.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    data_d    = data_q;
    bit_cnt_d = bit_cnt_q;
    ack_err_d = ack_err_q;
    case (state_q)
      IDLE: begin
        if (wr_start && en) begin
          addr_d    = addr;
          data_d    = wr_byte;
          ack_err_d = 1'b0;
          state_d   = START;
        end
      end
      START: begin
        if (bit_end) begin
          state_d   = ADDR;
          bit_cnt_d = 3'd7;
        end
      end
      ADDR: begin
        if (bit_end) begin
          if (bit_cnt_q == 3'd0) state_d = ADDR_ACK;
          else                   bit_cnt_d = bit_cnt_q - 3'd1;
        end
      end
      ADDR_ACK: begin
        if (sample && sda_i) ack_err_d = 1'b1;
        if (bit_end) begin
          if (ack_err_q) begin
            state_d = STOP;
          end else begin
            state_d   = DATA;
            bit_cnt_d = 3'd7;
          end
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_cnt_q == 3'd0) state_d = DATA_ACK;
          else                   bit_cnt_d = bit_cnt_q - 3'd1;
        end
      end
      DATA_ACK: begin
        if (sample && sda_i) ack_err_d = 1'b1;
        if (bit_end) state_d = STOP;
      end
      STOP: begin
        if (bit_end) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and transaction registers; reset aborts at once and releases the bus.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      addr_q    <= 7'd0;
      data_q    <= 8'd0;
      bit_cnt_q <= 3'd0;
      ack_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      bit_cnt_q <= bit_cnt_d;
      ack_err_q <= ack_err_d;
    end
  end

  // Bus drive per state and quarter: SCL low in Q0/Q3 of each bit, SDA steady across a bit.
  always_comb begin
    scl_oe = 1'b0;
    sda_oe = 1'b0;
    busy   = run;
    done   = (state_q == DONE);
    case (state_q)
      START: begin
        sda_oe = (phase >= 2'd2);
        scl_oe = (phase == 2'd3);
      end
      ADDR: begin
        scl_oe = (phase == 2'd0) || (phase == 2'd3);
        sda_oe = !addr_byte[bit_cnt_q];
      end
      DATA: begin
        scl_oe = (phase == 2'd0) || (phase == 2'd3);
        sda_oe = !data_q[bit_cnt_q];
      end
      ADDR_ACK, DATA_ACK: begin
        scl_oe = (phase == 2'd0) || (phase == 2'd3);
      end
      STOP: begin
        scl_oe = (phase == 2'd0);
        sda_oe = (phase <= 2'd1);
      end
      default: begin
      end
    endcase
  end

  assign ack_err = ack_err_q;

endmodule

// File: tb/tb_i2c_master_single_byte.sv
// Self-checking bench for i2c_master_single_byte. A bus-level monitor and a
// simple slave watch the wired-AND SCL/SDA lines; expected bit streams and
// timing are derived from the I2C frame layout, not from the RTL.
module tb_i2c_master_single_byte;

  localparam int C = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic [6:0] addr = 7'd0;
  logic       wr_start = 1'b0;
  logic [7:0] wr_byte = 8'd0;
  logic       busy, done, ack_err, scl_oe, sda_oe;
  logic       scl_i, sda_i;

  logic       slave_scl_low = 1'b0;
  logic       slave_sda_low = 1'b0;
  logic       ack_addr = 1'b1;
  logic       ack_data = 1'b1;

  int         vectors = 0;
  int         miscompares = 0;

  logic [31:0] mon_bits = 32'd0;
  int          mon_nbits = 0;
  int          mon_starts = 0;
  int          mon_stops = 0;
  int          done_cnt = 0;
  logic        scl_p = 1'b1;
  logic        sda_p = 1'b1;
  logic        cur_bit = 1'b0;
  logic        changed = 1'b1;

  assign scl_i = !(scl_oe || slave_scl_low);
  assign sda_i = !(sda_oe || slave_sda_low);

  i2c_master_single_byte #(
    .CLK_DIV(C)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .addr    (addr),
    .wr_start(wr_start),
    .wr_byte (wr_byte),
    .busy    (busy),
    .done    (done),
    .ack_err (ack_err),
    .scl_oe  (scl_oe),
    .sda_oe  (sda_oe),
    .scl_i   (scl_i),
    .sda_i   (sda_i)
  );

  // 10 ns system clock.
  always #5 clk = ~clk;

  // Bus monitor and slave: decode START/STOP, collect bits clocked while SCL
  // is high, pull SDA low for the ACK slots the slave is told to acknowledge.
  always @(negedge clk) begin
    if (scl_i && scl_p) begin
      if (sda_p && !sda_i) begin
        mon_starts    <= mon_starts + 1;
        mon_stops     <= 0;
        mon_bits      <= 32'd0;
        mon_nbits     <= 0;
        changed       <= 1'b1;
        slave_sda_low <= 1'b0;
      end else if (!sda_p && sda_i) begin
        mon_stops <= mon_stops + 1;
        changed   <= 1'b1;
      end
    end
    if (scl_i && !scl_p) begin
      changed <= 1'b0;
      cur_bit <= sda_i;
    end
    if (!scl_i && scl_p && !changed) begin
      mon_bits  <= {mon_bits[30:0], cur_bit};
      mon_nbits <= mon_nbits + 1;
      if (mon_nbits + 1 == 8)  slave_sda_low <= ack_addr;
      if (mon_nbits + 1 == 9)  slave_sda_low <= 1'b0;
      if (mon_nbits + 1 == 17) slave_sda_low <= ack_data;
      if (mon_nbits + 1 == 18) slave_sda_low <= 1'b0;
    end
    if (done === 1'b1) done_cnt <= done_cnt + 1;
    scl_p <= scl_i;
    sda_p <= sda_i;
  end

  // One comparison: counts every vector and reports any miscompare.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Request a write; returns at the negedge after the accepting clock edge.
  task automatic startTxn(input logic [6:0] a, input logic [7:0] d);
    @(negedge clk);
    en       = 1'b1;
    addr     = a;
    wr_byte  = d;
    wr_start = 1'b1;
    @(negedge clk);
    wr_start = 1'b0;
  endtask

  // Full transaction with bus-level expectations built from the frame layout.
  task automatic applyStimulus(input logic [6:0] a, input logic [7:0] d,
                               input logic ack_a, input logic ack_d,
                               input logic inject, input logic drop_en,
                               input int stretch);
    logic [31:0] exp_bits;
    int          exp_n;
    int          exp_cycles;
    int          cycles;
    int          done0;
    exp_bits = {25'd0, a} << 1;
    exp_bits = (exp_bits << 1) | {31'd0, !ack_a};
    exp_n    = 9;
    if (ack_a) begin
      exp_bits = (exp_bits << 8) | {24'd0, d};
      exp_bits = (exp_bits << 1) | {31'd0, !ack_d};
      exp_n    = 18;
    end
    exp_cycles = (ack_a ? 20 : 11) * 4 * C + stretch;
    ack_addr   = ack_a;
    ack_data   = ack_d;
    done0      = done_cnt;
    startTxn(a, d);
    checkOutput("busy_rise", {31'd0, busy}, 32'd1);
    checkOutput("ack_err_clr", {31'd0, ack_err}, 32'd0);
    cycles = 0;
    while (done !== 1'b1 && cycles < exp_cycles + 200) begin
      if (inject && cycles == 100) begin
        wr_start = 1'b1;
        wr_byte  = 8'h55;
      end else begin
        wr_start = 1'b0;
      end
      if (drop_en && cycles == 50) en = 1'b0;
      if (stretch > 0 && cycles == 12 * C + 1) slave_scl_low = 1'b1;
      if (stretch > 0 && cycles == 13 * C + stretch) slave_scl_low = 1'b0;
      @(negedge clk);
      cycles++;
    end
    wr_start      = 1'b0;
    slave_scl_low = 1'b0;
    checkOutput("done_latency", cycles, exp_cycles);
    checkOutput("busy_at_done", {31'd0, busy}, 32'd0);
    checkOutput("ack_err", {31'd0, ack_err}, {31'd0, !(ack_a && ack_d)});
    @(negedge clk);
    checkOutput("done_width", {31'd0, done}, 32'd0);
    checkOutput("bit_count", mon_nbits, exp_n);
    checkOutput("bit_stream", mon_bits, exp_bits);
    checkOutput("stop_seen", mon_stops, 1);
    checkOutput("lines_idle", {30'd0, scl_oe, sda_oe}, 32'd0);
    repeat (8 * C) @(negedge clk);
    checkOutput("single_done", done_cnt - done0, 1);
    checkOutput("idle_after", {31'd0, busy}, 32'd0);
    en = 1'b1;
  endtask

  // Directed and randomized sequence, ending in the summary line.
  initial begin
    logic [6:0] ra;
    logic [7:0] rd;
    int         starts0;
    $display("[TB] start, CLK_DIV=%0d", C);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    checkOutput("rst_ack_err", {31'd0, ack_err}, 32'd0);
    checkOutput("rst_lines", {30'd0, scl_oe, sda_oe}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    applyStimulus(7'h10, 8'hAC, 1'b1, 1'b1, 1'b0, 1'b0, 0);
    applyStimulus(7'h10, 8'hAC, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    applyStimulus(7'h10, 8'hAC, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    applyStimulus(7'h10, 8'hAC, 1'b1, 1'b1, 1'b1, 1'b0, 0);
    applyStimulus(7'h2B, 8'h3C, 1'b1, 1'b1, 1'b0, 1'b1, 0);

    // en low: request ignored, bus untouched
    starts0 = mon_starts;
    @(negedge clk);
    en       = 1'b0;
    wr_start = 1'b1;
    @(negedge clk);
    wr_start = 1'b0;
    checkOutput("en0_busy", {31'd0, busy}, 32'd0);
    repeat (20) @(negedge clk);
    checkOutput("en0_idle", {29'd0, busy, scl_oe, sda_oe}, 32'd0);
    checkOutput("en0_no_start", mon_starts - starts0, 0);

    // reset in the middle of the data byte
    ack_addr = 1'b1;
    ack_data = 1'b1;
    startTxn(7'h10, 8'hAC);
    repeat (48 * C + 5) @(negedge clk);
    checkOutput("pre_rst_busy", {31'd0, busy}, 32'd1);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("abort_state", {28'd0, busy, done, scl_oe, sda_oe}, 32'd0);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      ra = 7'($urandom_range(0, 127));
      rd = 8'($urandom_range(0, 255));
      applyStimulus(ra, rd, ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
                    1'b0, 1'b0, 0);
    end

`ifdef I2C_CLK_STRETCH_EN
    applyStimulus(7'h10, 8'hAC, 1'b1, 1'b1, 1'b0, 1'b0, 500);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
